// File: rtl/gate_exer_pkg.sv
// Shared types and constants for the 2-input gate exerciser.
package gate_exer_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StApply,
        StFinish
    } state_e;

    localparam int unsigned NUM_VECTORS = 4;

    // Truth tables: bit index = {A,B}
    localparam logic [3:0] TRUTH_AND  = 4'b1000;
    localparam logic [3:0] TRUTH_OR   = 4'b1110;
    localparam logic [3:0] TRUTH_XOR  = 4'b0110;
    localparam logic [3:0] TRUTH_NAND = 4'b0111;

endpackage

// File: rtl/gate_exer_hold_timer.sv
// Hold-time counter: counts 0..HOLD_CYCLES-1 while enabled, wraps on terminal count.
module gate_exer_hold_timer #(
    parameter int unsigned HOLD_CYCLES = 20
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic en_i,
    output logic tc_o
);

    localparam int unsigned CntW = $clog2(HOLD_CYCLES + 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    assign tc_o = (cnt_q == CntW'(HOLD_CYCLES - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = tc_o ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/gate_exerciser.sv
// Sequences {A,B} through 00..11, samples O after each hold window and checks it against EXPECT.
// Optional macro GATE_EXER_STOP_ON_FAIL_EN: finish the run at the first mismatch.
module gate_exerciser
    import gate_exer_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 20,
    parameter logic [3:0]  EXPECT      = TRUTH_AND
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       START,
    input  logic       O,
    output logic       A,
    output logic       B,
    output logic       BUSY,
    output logic       DONE,
    output logic       PASS,
    output logic [2:0] ERR_CNT,
    output logic [3:0] MISMATCH
);

    state_e     state_q, state_d;
    logic [1:0] idx_q, idx_d;
    logic       a_q, a_d, b_q, b_d;
    logic       pass_q, pass_d;
    logic [2:0] err_q, err_d;
    logic [3:0] mm_q, mm_d;
    logic       tmr_clear, tmr_en, tmr_tc;
    logic       fail;
    logic       last_vec;
    logic [1:0] idx_next;

    gate_exer_hold_timer #(
        .HOLD_CYCLES(HOLD_CYCLES)
    ) u_hold_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear_i(tmr_clear),
        .en_i   (tmr_en),
        .tc_o   (tmr_tc)
    );

    assign idx_next = idx_q + 2'd1;
    assign last_vec = (idx_q == 2'(NUM_VECTORS - 1));

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        a_d       = a_q;
        b_d       = b_q;
        pass_d    = pass_q;
        err_d     = err_q;
        mm_d      = mm_q;
        tmr_clear = 1'b0;
        tmr_en    = 1'b0;
        fail      = 1'b0;

        unique case (state_q)
            StIdle: begin
                a_d = 1'b0;
                b_d = 1'b0;
                if (START) begin
                    state_d   = StApply;
                    idx_d     = 2'd0;
                    tmr_clear = 1'b1;
                    mm_d      = 4'd0;
                    err_d     = 3'd0;
                    pass_d    = 1'b0;
                end
            end
            StApply: begin
                tmr_en = 1'b1;
                if (tmr_tc) begin
                    fail = (O != EXPECT[idx_q]);
                    if (fail) begin
                        mm_d[idx_q] = 1'b1;
                        err_d       = err_q + 3'd1;
                    end
`ifdef GATE_EXER_STOP_ON_FAIL_EN
                    if (last_vec || fail) begin
`else
                    if (last_vec) begin
`endif
                        state_d = StFinish;
                        a_d     = 1'b0;
                        b_d     = 1'b0;
                    end else begin
                        idx_d      = idx_next;
                        {a_d, b_d} = idx_next;
                    end
                end
            end
            StFinish: begin
                pass_d  = (mm_q == 4'd0);
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            idx_q   <= 2'd0;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= 3'd0;
            mm_q    <= 4'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
            mm_q    <= mm_d;
        end
    end

    assign A        = a_q;
    assign B        = b_q;
    assign BUSY     = (state_q == StApply);
    assign DONE     = (state_q == StFinish);
    assign PASS     = pass_q;
    assign ERR_CNT  = err_q;
    assign MISMATCH = mm_q;

endmodule
